// File: rtl/srl_var_delay_bus.sv
// srl_var_delay_bus: multi-channel programmable delay line with valid tracking and drain-before-change delay updates
module srl_var_delay_bus #(
  parameter int C_MAX_DELAY    = 16,
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 1,
  parameter int C_RESET_DELAY  = 1,
  parameter int C_DLY_WIDTH    = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ce,
  input  logic                                   flush,
  input  logic [C_DLY_WIDTH-1:0]                 cfg_delay,
  input  logic                                   cfg_load,
  output logic                                   cfg_busy,
  output logic [C_DLY_WIDTH-1:0]                 active_delay,
  input  logic                                   valid_in,
  input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] data_in,
  output logic                                   valid_out,
  output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] data_out,
  output logic [C_DLY_WIDTH-1:0]                 inflight_count
);
  localparam int W = C_NUM_CHANNELS * C_DATA_WIDTH;
  localparam logic [C_DLY_WIDTH-1:0] MAXD = C_DLY_WIDTH'(C_MAX_DELAY);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [C_DLY_WIDTH-1:0] active_q, active_d, pending_q, pending_d, cnt_q, cnt_d, clamp;
  logic [C_MAX_DELAY-1:0] vld_q, vld_d, mask;
  logic [W-1:0] dat_q [C_MAX_DELAY];
  logic [W-1:0] dat_d [C_MAX_DELAY];
  logic [W-1:0] dtap;
  logic vacc, vtap;
  assign cfg_busy       = state_q == DRAIN;
  assign active_delay   = active_q;
  assign inflight_count = cnt_q;
  assign vacc           = valid_in & ~cfg_busy & ~flush;
  assign valid_out      = active_q == '0 ? vacc : vtap;
  assign data_out       = valid_out ? (active_q == '0 ? data_in : dtap) : '0;
  always_comb begin
    vtap = 1'b0;
    dtap = '0;
    for (int k = 0; k < C_MAX_DELAY; k++) begin
      mask[k] = active_q > C_DLY_WIDTH'(k);
      if (active_q == C_DLY_WIDTH'(k + 1)) begin
        vtap = vld_q[k];
        dtap = dat_q[k];
      end
    end
    // stages at or beyond the active delay are kept empty so a later, longer delay never revives stale samples
    vld_d = flush ? '0 : ce ? C_MAX_DELAY'({vld_q, vacc}) & mask : vld_q;
    dat_d[0] = ce ? data_in : dat_q[0];
    for (int k = 1; k < C_MAX_DELAY; k++) dat_d[k] = ce ? dat_q[k-1] : dat_q[k];
    cnt_d = (flush || active_q == '0) ? '0 : ce ? cnt_q + C_DLY_WIDTH'(vacc) - C_DLY_WIDTH'(vtap) : cnt_q;
    clamp = cfg_delay > MAXD ? MAXD : cfg_delay;
    pending_d = cfg_load ? clamp : pending_q;
    state_d = state_q;
    active_d = active_q;
    if (flush) begin
      state_d = RUN;
      if (cfg_load || state_q == DRAIN) active_d = pending_d;
    end else if (state_q == RUN && cfg_load) begin
      if (cnt_q == '0 && !vacc) active_d = clamp;
      else state_d = DRAIN;
    end else if (state_q == DRAIN && cnt_q == '0) begin
      state_d = RUN;
      active_d = pending_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      active_q  <= C_DLY_WIDTH'(C_RESET_DELAY);
      pending_q <= C_DLY_WIDTH'(C_RESET_DELAY);
      cnt_q     <= '0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
    end
  end
  always_ff @(posedge clk) dat_q <= dat_d;
endmodule

// File: tb/tb_srl_var_delay_bus.sv
// tb_srl_var_delay_bus: randomized scoreboard bench; model tags each accepted sample with the ce-edge count it must appear at
module tb_srl_var_delay_bus;
  logic clk = 0, rst = 1, ce = 0, flush = 0, cfg_load = 0, valid_in = 0;
  logic [4:0] cfg_delay = 0;
  logic cfg_busy, valid_out;
  logic [4:0] active_delay, inflight_count;
  logic [31:0] data_in = 0, data_out;

  srl_var_delay_bus dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .cfg_delay(cfg_delay), .cfg_load(cfg_load),
    .cfg_busy(cfg_busy), .active_delay(active_delay), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .inflight_count(inflight_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; int tag;} ent_t;
  ent_t q[$];
  int vectors = 0, errors = 0;
  int e = 0, m_delay = 1, m_pending = 1;
  bit m_busy = 0, pushed_now = 0, mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare presented output against scoreboard head, consume on ce
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      bit exp_v;
      chk("active_delay", 64'(active_delay), 64'(m_delay));
      chk("cfg_busy", 64'(cfg_busy), 64'(m_busy));
      if (m_delay != 0) chk("inflight", 64'(inflight_count), 64'(q.size() - int'(pushed_now)));
      if (q.size() > 0 && q[0].tag < e) begin
        chk("lost_sample", 64'(q[0].tag), 64'(e));
        void'(q.pop_front());
      end
      exp_v = q.size() > 0 && q[0].tag == e;
      chk("valid_out", 64'(valid_out), 64'(exp_v));
      if (exp_v && valid_out) chk("data_out", 64'(data_out), 64'(q[0].d));
      if (!valid_out) chk("data_mask", 64'(data_out), 64'd0);
      if (exp_v && ce) void'(q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic c, input logic f,
                      input logic ld, input logic [4:0] cd);
    logic vacc;
    int cnt, cl;
    if (m_delay == 0) c = 1;
    vacc = v & ~m_busy & ~f;
    cnt = q.size();
    valid_in = v; data_in = d; ce = c; flush = f; cfg_load = ld; cfg_delay = cd;
    if (vacc && c) begin
      q.push_back('{d, e + m_delay});
      pushed_now = 1;
    end
    @(posedge clk); #1;
    pushed_now = 0;
    if (c) e++;
    if (f) q.delete();
    cl = int'(cd) > 16 ? 16 : int'(cd);
    if (f) begin
      if (ld) m_delay = cl;
      else if (m_busy) m_delay = m_pending;
      m_busy = 0;
    end else if (!m_busy && ld) begin
      if (cnt == 0 && !vacc) m_delay = cl;
      else m_busy = 1;
    end else if (m_busy && cnt == 0) begin
      m_delay = ld ? cl : m_pending;
      m_busy = 0;
    end
    if (ld) m_pending = cl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 1, 0, 0, 0);
  endtask

  task automatic do_reset;
    mon_en = 0;
    rst = 1; valid_in = 0; ce = 0; flush = 0; cfg_load = 0;
    @(posedge clk); #1;
    rst = 0;
    q.delete(); m_delay = 1; m_pending = 1; m_busy = 0;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_inflight", 64'(inflight_count), 64'd0);
    chk("rst_busy", 64'(cfg_busy), 64'd0);
    chk("rst_active", 64'(active_delay), 64'd1);
    mon_en = 1;
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    step(1, 32'h11, 1, 0, 0, 0);
    step(1, 32'h22, 1, 0, 0, 0);
    step(1, 32'h33, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 1, 5);
    chk("idle_load", 64'(active_delay), 64'd5);
    step(1, 32'hA5, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, i[0], 0, 0, 0);
    idle(2);
    step(1, 32'h101, 1, 0, 0, 0);
    step(1, 32'h102, 1, 0, 0, 0);
    step(1, 32'h103, 1, 0, 0, 0);
    step(1, 32'h104, 1, 0, 1, 2);
    step(1, 32'h105, 1, 0, 0, 0);
    idle(8);
    chk("drain_done", 64'(active_delay), 64'd2);
    step(1, 32'h106, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 1, 31);
    chk("clamp", 64'(active_delay), 64'd16);
    step(1, 32'hC0DE, 1, 0, 0, 0);
    idle(18);
    step(0, 0, 1, 0, 1, 8);
    for (int i = 0; i < 4; i++) step(1, 32'h200 + i, 1, 0, 0, 0);
    step(1, 32'h2FF, 1, 1, 0, 0);
    chk("flush_cnt", 64'(inflight_count), 64'd0);
    idle(10);
    for (int i = 0; i < 4; i++) step(1, 32'h300 + i, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1, 3);
    chk("flush_load", 64'(active_delay), 64'd3);
    idle(5);
    step(0, 0, 1, 0, 1, 0);
    step(1, 32'hDEAD, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 5);
    for (int i = 0; i < 3; i++) step(1, 32'h400 + i, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 7);
    step(0, 0, 0, 0, 0, 0);
    chk("drain_busy", 64'(cfg_busy), 64'd1);
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, 5'($urandom_range(0, 31)));
    guard = 0;
    while ((q.size() > 0 || m_busy) && guard < 200) begin
      step(0, 0, 1, 0, 0, 0);
      guard++;
    end
    chk("final_drain", 64'(q.size()), 64'd0);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
